// File: rtl/mem_port_arbiter.sv
// Shares one MAR/MBR memory port between instruction fetch (IF) and load/store (LS).
// Runs the MFA/MFC handshake with a wait-state timeout and bounded LS-over-IF priority.
//
//   state  | meaning
//   IDLE   | no access in flight; selects the owner of the next access
//   ACCESS | MFA high, waiting for MFC or timeout
//   DONE   | one-cycle ack to the owner; rdata/err valid
module mem_port_arbiter #(
    parameter int DATA_W       = 32,
    parameter int TIMEOUT      = 15,
    parameter int LS_BURST_MAX = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_if,
    input  logic [DATA_W-1:0] addr_if,
    output logic              ack_if,
    input  logic              req_ls,
    input  logic [DATA_W-1:0] addr_ls,
    input  logic [DATA_W-1:0] wdata_ls,
    input  logic              rw_ls,
    input  logic              wb_ls,
    output logic              ack_ls,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              MFA,
    input  logic              MFC,
    output logic              READ_WRITE,
    output logic              WORD_BYTE,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] RUN_MAX   = 8'(LS_BURST_MAX);

    state_t     state;
    logic       owner_ls;
    logic [7:0] wait_cnt;
    logic [7:0] ls_run;
    logic       grant_ls;

    // LS wins ties until it has taken RUN_MAX grants in a row over a waiting IF.
    always_comb begin
        grant_ls = 1'b0;
        if (req_ls && !(req_if && ls_run == RUN_MAX))
            grant_ls = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            owner_ls   <= 1'b0;
            wait_cnt   <= '0;
            ls_run     <= '0;
            ack_if     <= 1'b0;
            ack_ls     <= 1'b0;
            rdata      <= '0;
            err        <= 1'b0;
            MFA        <= 1'b0;
            READ_WRITE <= 1'b1;
            WORD_BYTE  <= 1'b1;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            ack_if <= 1'b0;
            ack_ls <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_if || req_ls) begin
                        state    <= ACCESS;
                        MFA      <= 1'b1;
                        wait_cnt <= '0;
                        owner_ls <= grant_ls;
                        if (grant_ls) begin
                            mem_addr   <= addr_ls;
                            mem_wdata  <= wdata_ls;
                            READ_WRITE <= rw_ls;
                            WORD_BYTE  <= wb_ls;
                            ls_run     <= req_if ? ls_run + 8'd1 : 8'd0;
                        end else begin
                            mem_addr   <= addr_if;
                            READ_WRITE <= 1'b1;
                            WORD_BYTE  <= 1'b1;
                            ls_run     <= '0;
                        end
                    end
                end
                ACCESS: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (MFC) begin
                        if (READ_WRITE)
                            rdata <= WORD_BYTE ? mem_rdata
                                               : {{(DATA_W-8){1'b0}}, mem_rdata[7:0]};
                        err    <= 1'b0;
                        MFA    <= 1'b0;
                        state  <= DONE;
                        ack_if <= !owner_ls;
                        ack_ls <= owner_ls;
                    end else if (wait_cnt == WAIT_LAST) begin
                        rdata  <= '0;
                        err    <= 1'b1;
                        MFA    <= 1'b0;
                        state  <= DONE;
                        ack_if <= !owner_ls;
                        ack_ls <= owner_ls;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
